// File: rtl/crt_pkg.sv
// Shared definitions for the residue-to-binary (CRT) converter.
//   - FSM state encoding
//   - MAX_MOD / MOD_W sizing constants
//   - constant functions used at elaboration to derive the modulus product,
//     the per-channel cofactors M/m_i and the result width
package crt_pkg;

    localparam int MAX_MOD = 4;
    localparam int MOD_W   = 4;   // every modulus lies in 2..15

    typedef enum logic [1:0] {
        ST_SETUP = 2'd0,
        ST_IDLE  = 2'd1,
        ST_ACC   = 2'd2,
        ST_DONE  = 2'd3
    } crt_state_e;

    function automatic int mod_sel(input int i, input int m0, input int m1,
                                   input int m2, input int m3);
        case (i)
            0:       return m0;
            1:       return m1;
            2:       return m2;
            default: return m3;
        endcase
    endfunction

    // Product of the first n moduli.
    function automatic int mod_product(input int n, input int m0, input int m1,
                                       input int m2, input int m3);
        int p;
        p = m0 * m1;
        if (n > 2) p = p * m2;
        if (n > 3) p = p * m3;
        return p;
    endfunction

    // Bits needed to hold 0..m-1.
    function automatic int result_width(input int m);
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

    // M/m_i for a used channel, 0 for an unused one.
    function automatic int cofactor(input int n, input int i, input int m0,
                                    input int m1, input int m2, input int m3);
        if (i >= n) return 0;
        return mod_product(n, m0, m1, m2, m3) / mod_sel(i, m0, m1, m2, m3);
    endfunction

    function automatic int cof_mod(input int cof, input int m);
        return (m == 0) ? 0 : cof % m;
    endfunction

endpackage

// File: rtl/crt_term.sv
// One CRT term: ((r * inv) mod m) * (M/m), purely combinational.
// Ports:
//   i_res  - channel residue r_i
//   i_inv  - cached inverse inv_i
//   i_mod  - channel modulus m_i (2..15)
//   i_cof  - cofactor M/m_i
//   o_term - resulting term, always < M for a legal residue
module crt_term
    import crt_pkg::*;
#(
    parameter int RES_W = 4,
    parameter int OUT_W = 16
) (
    input  logic [RES_W-1:0] i_res,
    input  logic [MOD_W-1:0] i_inv,
    input  logic [MOD_W-1:0] i_mod,
    input  logic [OUT_W-1:0] i_cof,
    output logic [OUT_W-1:0] o_term
);

    localparam int PW = RES_W + MOD_W;   // r * inv width
    localparam int RW = PW + MOD_W;      // room for m << (PW-1)

    logic [PW-1:0] w_prod;
    logic [RW-1:0] w_rem;

    // Narrow restoring reduction: subtract m<<k for k high to low. Each step
    // keeps rem < m<<k, so after k=0 the remainder is below m.
    always_comb begin
        w_prod = PW'(i_res) * PW'(i_inv);
        w_rem  = RW'(w_prod);
        for (int k = PW - 1; k >= 0; k--) begin
            if (w_rem >= (RW'(i_mod) << k))
                w_rem = w_rem - (RW'(i_mod) << k);
        end
        o_term = OUT_W'(w_rem) * i_cof;
    end

endmodule

// File: rtl/crt_converter.sv
// Residue-number to binary converter using the Chinese Remainder Theorem.
// After reset the block searches the modular inverses once (SETUP), then
// converts one word at a time: capture in IDLE, one channel per cycle in ACC
// plus one output-latch cycle, result held in DONE until accepted.
// Ports:
//   i_clock, i_reset_n        - clock, async active-low reset
//   i_in_valid / o_in_ready   - input handshake, i_in_residues packed per channel
//   o_out_valid / i_out_ready - output handshake
//   o_out_value, o_out_error  - binary result / illegal-residue flag
//   o_config_error            - sticky: moduli not pairwise coprime
module crt_converter
    import crt_pkg::*;
#(
    parameter int NUM_MOD = 3,
    parameter int MOD0    = 8,
    parameter int MOD1    = 7,
    parameter int MOD2    = 5,
    parameter int MOD3    = 1,
    parameter int RES_W   = 4,
    parameter int OUT_W   = 16
) (
    input  logic                     i_clock,
    input  logic                     i_reset_n,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [NUM_MOD*RES_W-1:0] i_in_residues,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [OUT_W-1:0]         o_out_value,
    output logic                     o_out_error,
    output logic                     o_config_error
);

    localparam int M_PROD = mod_product(NUM_MOD, MOD0, MOD1, MOD2, MOD3);
    localparam int CH_W   = 3;                 // counts up to NUM_MOD inclusive
    localparam int IDX_W  = $clog2(MAX_MOD);
    localparam int AMOD0  = cof_mod(cofactor(NUM_MOD, 0, MOD0, MOD1, MOD2, MOD3), MOD0);

    if (NUM_MOD < 2 || NUM_MOD > MAX_MOD) begin : g_bad_num
        $error("crt_converter: NUM_MOD must be 2..4");
    end
    if (OUT_W < result_width(M_PROD)) begin : g_bad_width
        $error("crt_converter: OUT_W too narrow for the modulus product");
    end

    // Per-channel constants: modulus, cofactor M/m_i and (M/m_i) mod m_i.
    logic [MAX_MOD-1:0][MOD_W-1:0] w_mod;
    logic [MAX_MOD-1:0][MOD_W-1:0] w_amod;
    logic [MAX_MOD-1:0][OUT_W-1:0] w_cof;

    for (genvar g = 0; g < MAX_MOD; g++) begin : g_const
        localparam int MG  = mod_sel(g, MOD0, MOD1, MOD2, MOD3);
        localparam int COF = cofactor(NUM_MOD, g, MOD0, MOD1, MOD2, MOD3);
        assign w_mod[g]  = MOD_W'(MG);
        assign w_cof[g]  = OUT_W'(COF);
        assign w_amod[g] = MOD_W'(cof_mod(COF, MG));
    end

    crt_state_e                    r_state, w_state_nxt;
    logic [CH_W-1:0]               r_ch;
    logic [MOD_W-1:0]              r_cand;
    logic [MOD_W-1:0]              r_prod;    // r_cand * amod mod m
    logic [MAX_MOD-1:0][MOD_W-1:0] r_inv;
    logic                          r_cfg_err;
    logic [MAX_MOD-1:0][RES_W-1:0] r_res;
    logic [OUT_W-1:0]              r_acc;
    logic                          r_err;
    logic [OUT_W-1:0]              r_out_value;
    logic                          r_out_error;

    logic [IDX_W-1:0] w_idx, w_idx_nxt;
    logic [OUT_W-1:0] w_term, w_acc_nxt;
    logic [OUT_W:0]   w_sum;
    logic [MOD_W:0]   w_prod_sum;
    logic [MOD_W-1:0] w_prod_nxt;
    logic             w_hit, w_exhausted, w_last_ch, w_acc_end, w_in_err;
    logic             w_in_ready, w_out_valid;

    assign w_idx     = r_ch[IDX_W-1:0];
    assign w_idx_nxt = w_idx + IDX_W'(1);

    // Inverse search: candidate c hits when c*(M/m) == 1 mod m. The product is
    // stepped by adding amod each cycle, so no multiply or divide is needed.
    assign w_prod_sum  = {1'b0, r_prod} + {1'b0, w_amod[w_idx]};
    assign w_prod_nxt  = (w_prod_sum >= {1'b0, w_mod[w_idx]})
                       ? MOD_W'(w_prod_sum - {1'b0, w_mod[w_idx]})
                       : w_prod_sum[MOD_W-1:0];
    assign w_hit       = (r_prod == MOD_W'(1));
    assign w_exhausted = (r_cand == w_mod[w_idx] - MOD_W'(1));
    assign w_last_ch   = (r_ch == CH_W'(NUM_MOD - 1));
    assign w_acc_end   = (r_ch == CH_W'(NUM_MOD));

    crt_term #(.RES_W(RES_W), .OUT_W(OUT_W)) u_term (
        .i_res  (r_res[w_idx]),
        .i_inv  (r_inv[w_idx]),
        .i_mod  (w_mod[w_idx]),
        .i_cof  (w_cof[w_idx]),
        .o_term (w_term)
    );

    // Both operands are below M, so one conditional subtract reduces the sum.
    assign w_sum     = {1'b0, r_acc} + {1'b0, w_term};
    assign w_acc_nxt = (w_sum >= (OUT_W+1)'(M_PROD))
                     ? OUT_W'(w_sum - (OUT_W+1)'(M_PROD))
                     : w_sum[OUT_W-1:0];

    always_comb begin
        w_in_err = 1'b0;
        for (int i = 0; i < NUM_MOD; i++) begin
            if (32'(i_in_residues[i*RES_W +: RES_W]) >= 32'(w_mod[i]))
                w_in_err = 1'b1;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) r_state <= ST_SETUP;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            ST_SETUP: if (!r_cfg_err && w_hit && w_last_ch) w_state_nxt = ST_IDLE;
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (i_in_valid) w_state_nxt = ST_ACC;
            end
            ST_ACC:   if (w_acc_end) w_state_nxt = ST_DONE;
            ST_DONE: begin
                w_out_valid = 1'b1;
                if (i_out_ready) w_state_nxt = ST_IDLE;
            end
            default:  w_state_nxt = ST_SETUP;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_ch        <= '0;
            r_cand      <= MOD_W'(1);
            r_prod      <= MOD_W'(AMOD0);
            r_inv       <= '0;
            r_cfg_err   <= 1'b0;
            r_res       <= '0;
            r_acc       <= '0;
            r_err       <= 1'b0;
            r_out_value <= '0;
            r_out_error <= 1'b0;
        end else begin
            case (r_state)
                ST_SETUP: begin
                    if (!r_cfg_err) begin
                        if (w_hit) begin
                            r_inv[w_idx] <= r_cand;
                            if (w_last_ch) begin
                                r_ch <= '0;
                            end else begin
                                r_ch   <= r_ch + CH_W'(1);
                                r_cand <= MOD_W'(1);
                                r_prod <= w_amod[w_idx_nxt];
                            end
                        end else if (w_exhausted) begin
                            r_cfg_err <= 1'b1;   // parks SETUP until reset
                        end else begin
                            r_cand <= r_cand + MOD_W'(1);
                            r_prod <= w_prod_nxt;
                        end
                    end
                end
                ST_IDLE: begin
                    if (i_in_valid) begin
                        for (int i = 0; i < NUM_MOD; i++)
                            r_res[i] <= i_in_residues[i*RES_W +: RES_W];
                        r_acc <= '0;
                        r_err <= w_in_err;
                        r_ch  <= '0;
                    end
                end
                ST_ACC: begin
                    // Channels 0..NUM_MOD-1 accumulate; the extra step latches
                    // the result so DONE holds it independent of r_acc.
                    if (w_acc_end) begin
                        r_out_value <= r_err ? '0 : r_acc;
                        r_out_error <= r_err;
                    end else begin
                        r_acc <= w_acc_nxt;
                        r_ch  <= r_ch + CH_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_in_ready     = w_in_ready;
    assign o_out_valid    = w_out_valid;
    assign o_out_value    = r_out_value;
    assign o_out_error    = r_out_error;
    assign o_config_error = r_cfg_err;

endmodule

// File: tb/tb_crt_converter.sv
module tb_crt_converter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, out_error, cfg_err;
    logic [11:0] res;
    logic [15:0] out_value;

    // Second instance with non-coprime moduli 4 and 6.
    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_error, c_cfg_err;
    logic [7:0]  c_res;
    logic [15:0] c_out_value;
    int          c_bad = 0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    crt_converter u_dut (
        .i_clock        (clk),
        .i_reset_n      (rst_n),
        .i_in_valid     (in_valid),
        .o_in_ready     (in_ready),
        .i_in_residues  (res),
        .o_out_valid    (out_valid),
        .i_out_ready    (out_ready),
        .o_out_value    (out_value),
        .o_out_error    (out_error),
        .o_config_error (cfg_err)
    );

    crt_converter #(.NUM_MOD(2), .MOD0(4), .MOD1(6)) u_cfg (
        .i_clock        (clk),
        .i_reset_n      (rst_n),
        .i_in_valid     (c_in_valid),
        .o_in_ready     (c_in_ready),
        .i_in_residues  (c_res),
        .o_out_valid    (c_out_valid),
        .i_out_ready    (c_out_ready),
        .o_out_value    (c_out_value),
        .o_out_error    (c_out_error),
        .o_config_error (c_cfg_err)
    );

    always @(posedge clk) if (c_in_ready || c_out_valid) c_bad++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Reference: the unique x in 0..M-1 matching every residue, found by search.
    function automatic void crt_ref(input int r0, input int r1, input int r2,
                                    output int val, output bit err);
        val = 0;
        err = (r0 >= 8) || (r1 >= 7) || (r2 >= 5);
        if (!err)
            for (int x = 0; x < 280; x++)
                if ((x % 8 == r0) && (x % 7 == r1) && (x % 5 == r2)) val = x;
    endfunction

    // Reference SETUP length: sum over channels of the smallest inverse.
    function automatic int ref_setup_edges();
        int m[3] = '{8, 7, 5};
        int total = 0;
        for (int ch = 0; ch < 3; ch++) begin
            int found = 0;
            for (int c = 1; c < m[ch]; c++)
                if (found == 0 && ((c * (280 / m[ch])) % m[ch]) == 1) found = c;
            total += found;
        end
        return total;
    endfunction

    task automatic convert(input int r0, input int r1, input int r2, input int hold);
        int ev, lat;
        bit ee;
        logic [15:0] v0;
        logic e0;
        crt_ref(r0, r1, r2, ev, ee);
        chk("pre_ready", in_ready, 1);
        res       = {4'(r2), 4'(r1), 4'(r0)};
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        tick();
        lat = 0;
        while (!out_valid && lat < 20) begin
            chk("busy_ready", in_ready, 0);
            in_valid = 1'($urandom_range(0, 1));   // must be ignored
            res      = 12'($urandom);
            tick();
            lat++;
        end
        in_valid = 1'b0;
        chk("latency", lat, 4);
        chk("value", out_value, ev);
        chk("error", out_error, ee);
        v0 = out_value;
        e0 = out_error;
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1;
            res      = 12'($urandom);
            tick();
            chk("hold_valid", out_valid, 1);
            chk("hold_value", out_value, v0);
            chk("hold_error", out_error, e0);
            chk("hold_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("ack_valid", out_valid, 0);
        chk("ack_ready", in_ready, 1);
    endtask

    initial begin
        int edges, seen, a, b, c, ch;
        rst_n = 1'b0; in_valid = 1'b0; res = '0; out_ready = 1'b0;
        c_in_valid = 1'b1; c_res = 8'h21; c_out_ready = 1'b1;
        tick(); tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_value", out_value, 0);
        chk("rst_out_error", out_error, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_cfg_dut_err", c_cfg_err, 0);
        rst_n = 1'b1;

        edges = 0;
        while (!in_ready && edges < 50) begin
            tick();
            edges++;
            if (edges == 2) chk("cfg_err_pre", c_cfg_err, 0);
            if (edges == 3) chk("cfg_err_set", c_cfg_err, 1);
        end
        chk("setup_edges", edges, ref_setup_edges());

        convert(6, 1, 3, 0);
        convert(3, 4, 3, 0);
        convert(3, 3, 3, 0);
        convert(9, 1, 3, 5);

        // Reset during ACC must discard the word and rerun SETUP.
        res = {4'd3, 4'd1, 4'd6}; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("mid_acc_ready", in_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", out_valid, 0);
        chk("abort_ready", in_ready, 0);
        tick();
        rst_n = 1'b1; out_ready = 1'b0;
        edges = 0; seen = 0;
        while (!in_ready && edges < 50) begin
            tick();
            edges++;
            if (out_valid) seen = 1;
        end
        chk("resetup_edges", edges, ref_setup_edges());
        chk("aborted_no_valid", seen, 0);
        convert(6, 1, 3, 2);

        for (int n = 0; n < 16; n++) begin
            a = $urandom_range(0, 7); b = $urandom_range(0, 6); c = $urandom_range(0, 4);
            if ($urandom_range(0, 4) == 0) begin
                ch = $urandom_range(0, 2);
                if (ch == 0) a = $urandom_range(8, 15);
                else if (ch == 1) b = $urandom_range(7, 15);
                else c = $urandom_range(5, 15);
            end
            convert(a, b, c, $urandom_range(0, 3));
        end

        chk("final_cfg_err", c_cfg_err, 1);
        chk("cfg_never_ready", c_bad, 0);
        chk("main_cfg_ok", cfg_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/crt_converter.md
CRT_CONVERTER -- requirements
Module: crt_converter

Interface
REQ-001 Parameter NUM_MOD, default 3: number of residue channels, legal range 2..4.
REQ-002 Parameters MOD0..MOD3, defaults 8, 7, 5, 1: channel moduli; only MOD0..MOD(NUM_MOD-1) are used; each used modulus is in 2..15.
REQ-003 Parameter RES_W, default 4: bit width of each residue field.
REQ-004 Parameter OUT_W, default 16: width of out_value; elaboration SHALL fail if OUT_W < clog2(M), where M = product of used moduli.
REQ-005 clock  in  1  sole clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 in_valid  in  1  in_residues holds a word to convert.
REQ-008 in_ready  out  1  block will accept a word this cycle.
REQ-009 in_residues  in  NUM_MOD*RES_W  channel i residue at bits [i*RES_W +: RES_W].
REQ-010 out_valid  out  1  out_value and out_error are valid.
REQ-011 out_ready  in  1  consumer accepts the result.
REQ-012 out_value  out  OUT_W  binary result in 0..M-1.
REQ-013 out_error  out  1  input word contained a residue >= its modulus.
REQ-014 config_error  out  1  sticky flag: the moduli are not pairwise coprime.

Function
REQ-015 The FSM SHALL have states SETUP, IDLE, ACC and DONE, and SHALL enter SETUP on reset release.
REQ-016 SETUP SHALL find inv_i, the modular inverse of (M/m_i) mod m_i, one candidate per cycle, starting at candidate 1, channel 0 first, moving to the next channel on a hit.
REQ-017 If channel i exhausts candidates 1..m_i-1 with no hit, the FSM SHALL set config_error and remain in SETUP with in_ready=0 until reset.
REQ-018 When all inverses are found, SETUP SHALL go to IDLE; the inverses SHALL be cached and not recomputed until the next reset.
REQ-019 in_ready SHALL be 1 only in IDLE; an in_valid&&in_ready cycle captures in_residues, clears the accumulator and goes to ACC.
REQ-020 in_valid while in_ready=0 SHALL be ignored.
REQ-021 ACC SHALL process one channel per cycle, channel 0 first:
- term_i = ((r_i*inv_i) mod m_i) * (M/m_i)
- acc = acc + term_i, minus M if the sum is >= M
- no full-width divider is permitted.
REQ-022 After channel NUM_MOD-1, the FSM SHALL go to DONE; out_valid SHALL rise exactly NUM_MOD+1 edges after the accepting edge.
REQ-023 Any captured r_i >= m_i SHALL give out_error=1 and out_value=0 with the same latency.
REQ-024 In DONE, out_value and out_error SHALL hold stable while out_ready=0.
REQ-025 On out_valid&&out_ready, the FSM SHALL go to IDLE; there is no overlap, so in_ready is 1 on the following cycle.
REQ-026 out_valid SHALL be 0 in all states except DONE.

Reset
REQ-027 While reset=0, outputs SHALL be: in_ready=0, out_valid=0, out_value=0, out_error=0, config_error=0.
REQ-028 While reset=0, the state SHALL be SETUP and the cached inverses SHALL be cleared.
REQ-029 Reset asserted mid-SETUP, mid-ACC or mid-DONE SHALL abort immediately, discard any in-flight result, and rerun SETUP after release.

Structure
REQ-030 Shared package crt_pkg SHALL hold:
- the FSM state enum
- MAX_MOD=4
- constant functions for the modulus product and the result width.
REQ-031 One sub-module, crt_term, SHALL compute term_i from r_i, inv_i, m_i and M/m_i in one cycle, combinationally.
REQ-032 The top level SHALL time-multiplex a single crt_term instance across channels.

Verification
REQ-033 Defaults, reset release -> in_ready first high after exactly 7 edges (inverse candidates 3+3+1); inverses 3, 3, 1.
REQ-034 Residues {6,1,3} (r8,r7,r5) -> out_value=78, out_error=0, out_valid 4 edges after acceptance.
REQ-035 Residues {3,4,3} -> 123; then {3,3,3} -> 3, sent back-to-back with out_ready=1 -> both correct; in_ready low during ACC and DONE.
REQ-036 Residues {9,1,3} -> out_error=1, out_value=0; with out_ready held low 5 cycles -> outputs stable, no new word accepted.
REQ-037 NUM_MOD=2, MOD0=4, MOD1=6 -> config_error=1 after channel-0 search, in_ready never asserts.
REQ-038 reset pulsed low during ACC of {6,1,3} -> out_valid never rises for that word; after re-SETUP, {6,1,3} -> 78.
